// File: rtl/vmsu_wb_pkg.sv
// Shared definitions for the Wishbone multiply unit: register offsets, bit indices and FSM states.
package vmsu_wb_pkg;

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_OPERANDS = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_RESULT   = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [31:0] RESET_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/vmsu_seq_mul.sv
// Sequential shift-add multiplier over unsigned WIDTH-bit magnitudes, one partial product per cycle.
// o_done marks the final iteration; o_product holds the full product from the following cycle.
module vmsu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a_mag,
    input  logic [WIDTH-1:0]     i_b_mag,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               w_last;

    assign w_last = r_busy && (r_cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a_mag};
            r_mplier <= i_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_product = r_acc;

endmodule

// File: rtl/wb_vmsu_slave.sv
// Wishbone B4 classic responder exposing the sequential multiplier as four 32-bit registers.
// Owns bus decode, ack generation, CTRL/OPERANDS/STATUS/RESULT, the run FSM, sign fix-up and irq.
module wb_vmsu_slave
    import vmsu_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIDTH     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    logic               r_ack;
    logic [31:0]        r_dat;
    logic               r_signed;
    logic               r_irq_en;
    logic               r_done;
    logic               r_err;
    logic               r_neg;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [2*WIDTH-1:0] r_result;
    state_t             r_state;

    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_hit;
    logic [1:0]         w_off;
    logic               w_wr;
    logic               w_wr_ctrl;
    logic               w_wr_ops;
    logic               w_wr_stat;
    logic               w_start_req;
    logic               w_signed_eff;
    logic               w_busy;
    logic               w_fin;
    logic               w_core_start;
    logic               w_start_err;
    logic               w_core_busy;
    logic               w_core_done;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_core_product;
    logic [2*WIDTH-1:0] w_product_fix;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    // A request held through its own ack cycle is blocked, so the earliest next ack is T+3.
    assign w_accept = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off    = wbs_adr_i[3:2];

    assign w_wr      = w_accept & w_hit & wbs_we_i;
    assign w_wr_ctrl = w_wr & (w_off == OFF_CTRL);
    assign w_wr_ops  = w_wr & (w_off == OFF_OPERANDS);
    assign w_wr_stat = w_wr & (w_off == OFF_STATUS);

    assign w_start_req  = w_wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_START];
    assign w_signed_eff = (w_wr_ctrl & wbs_sel_i[0]) ? wbs_dat_i[CTRL_SIGNED] : r_signed;

    assign w_a_mag = (w_signed_eff && r_op_a[WIDTH-1]) ? -r_op_a : r_op_a;
    assign w_b_mag = (w_signed_eff && r_op_b[WIDTH-1]) ? -r_op_b : r_op_b;

    vmsu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_core_start),
        .i_a_mag   (w_a_mag),
        .i_b_mag   (w_b_mag),
        .o_busy    (w_core_busy),
        .o_done    (w_core_done),
        .o_product (w_core_product)
    );

    assign w_product_fix = r_neg ? -w_core_product : w_core_product;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_req) w_state_nxt = RUN;
            RUN:     if (w_core_done) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy       = 1'b0;
        w_fin        = 1'b0;
        w_core_start = 1'b0;
        w_start_err  = 1'b0;
        case (r_state)
            IDLE: w_core_start = w_start_req;
            RUN: begin
                w_busy      = 1'b1;
                w_start_err = w_start_req;
            end
            FIN: begin
                w_busy      = 1'b1;
                w_fin       = 1'b1;
                w_start_err = w_start_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed <= 1'b0;
            r_irq_en <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_wr_ctrl && wbs_sel_i[0]) begin
                r_signed <= wbs_dat_i[CTRL_SIGNED];
                r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (w_wr_ops && wbs_sel_i[0]) r_op_a <= wbs_dat_i[WIDTH-1:0];
            if (w_wr_ops && wbs_sel_i[1]) r_op_b <= wbs_dat_i[8 +: WIDTH];

            // The FIN set is ordered after the W1C clear so it wins a same-cycle collision.
            if (w_wr_stat && wbs_sel_i[0] && wbs_dat_i[STAT_DONE]) r_done <= 1'b0;
            if (w_fin) begin
                r_done   <= 1'b1;
                r_result <= w_product_fix;
            end

            if (w_wr_stat && wbs_sel_i[0] && wbs_dat_i[STAT_ERR]) r_err <= 1'b0;
            if (w_start_err) r_err <= 1'b1;

            if (w_core_start) r_neg <= w_signed_eff & (r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1]);
        end
    end

    always_comb begin
        w_rd_data = RESET_DATA;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL: begin
                    w_rd_data[CTRL_SIGNED] = r_signed;
                    w_rd_data[CTRL_IRQ_EN] = r_irq_en;
                end
                OFF_OPERANDS: w_rd_data[2*WIDTH-1:0] = {r_op_b, r_op_a};
                OFF_STATUS: begin
                    w_rd_data[STAT_BUSY] = w_busy;
                    w_rd_data[STAT_DONE] = r_done;
                    w_rd_data[STAT_ERR]  = r_err;
                end
                OFF_RESULT: w_rd_data[2*WIDTH-1:0] = r_result;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= RESET_DATA;
        end else begin
            r_ack <= w_accept;
            r_dat <= (w_accept && !wbs_we_i) ? w_rd_data : RESET_DATA;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_done & r_irq_en;

    // Address byte offset, upper write lanes and the core's own busy flag carry no information here.
    assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2], w_core_busy};

endmodule

// File: tb/tb_wb_vmsu_slave.sv
// Self-checking bench for wb_vmsu_slave: a cycle-stamped register model predicts every read,
// a scoreboard queue carries the predictions and a negedge monitor compares them on each ack.
module tb_wb_vmsu_slave;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          WIDTH   = 8;
    localparam logic [31:0] A_CTRL  = BASE + 32'h0;
    localparam logic [31:0] A_OPS   = BASE + 32'h4;
    localparam logic [31:0] A_STAT  = BASE + 32'h8;
    localparam logic [31:0] A_RES   = BASE + 32'hC;
    localparam logic [31:0] A_UNMAP = 32'h3000_0010;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb   = 1'b0;
    logic        cyc_i = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'h0;
    logic [31:0] adr   = 32'h0;
    logic [31:0] dat   = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic        irq;

    wb_vmsu_slave #(
        .BASE_ADDR (BASE),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc_i),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    // Register model: firmware-visible state plus the cycle at which the pending product lands.
    bit          m_signed, m_irq_en, m_done, m_err, m_pend;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_result, m_prod;
    int          m_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        int x;
        int y;
        int p;
        x = sgn ? int'($signed(a)) : int'(a);
        y = sgn ? int'($signed(b)) : int'(b);
        p = x * y;
        return p[15:0];
    endfunction

    function automatic bit is_mapped(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    task automatic model_reset();
        m_signed = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_pend = 0;
        m_a = 8'h0; m_b = 8'h0; m_result = 16'h0; m_prod = 16'h0; m_t = 0;
    endtask

    // Product becomes visible, with DONE, WIDTH+2 cycles after the accepted START.
    task automatic model_advance(input int c);
        if (m_pend && c >= m_t + WIDTH + 2) begin
            m_done   = 1;
            m_result = m_prod;
            m_pend   = 0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (is_mapped(a)) begin
            case (a[3:2])
                2'd0: r = {29'h0, m_irq_en, m_signed, 1'b0};
                2'd1: r = {16'h0, m_b, m_a};
                2'd2: r = {29'h0, m_err, m_done, m_pend};
                default: r = {16'h0, m_result};
            endcase
        end
        return r;
    endfunction

    task automatic model_write(input int c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!is_mapped(a)) return;
        case (a[3:2])
            2'd0: if (s[0]) begin
                m_signed = d[1];
                m_irq_en = d[2];
                if (d[0]) begin
                    if (m_pend) m_err = 1;
                    else begin
                        m_pend = 1;
                        m_t    = c;
                        m_prod = ref_mul(m_a, m_b, m_signed);
                    end
                end
            end
            2'd1: begin
                if (s[0]) m_a = d[7:0];
                if (s[1]) m_b = d[15:8];
            end
            2'd2: if (s[0]) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err  = 0;
            end
            default: ;
        endcase
    endtask

    // One classic access: request held in cycles C and C+1, ack expected exactly in C+1.
    task automatic wb_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string name);
        sb_t e;
        int  c;
        c = cyc;
        model_advance(c);
        check({name, "_irq"}, 32'(irq), 32'(m_done & m_irq_en));
        e.rd   = !w;
        e.exp  = w ? 32'h0 : model_read(a);
        e.name = name;
        sb_q.push_back(e);
        if (w) model_write(c, a, d, s);
        stb = 1'b1; cyc_i = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(negedge clk);
        check({name, "_ack_lo"}, 32'(ack), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_ack_hi"}, 32'(ack), 32'h1);
        @(posedge clk); #1;
        stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string n);
        wb_access(1'b1, a, d, s, n);
    endtask

    task automatic rd(input logic [31:0] a, input string n);
        wb_access(1'b0, a, 32'h0, 4'hF, n);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_ack", 32'(ack), 32'h0);
            @(posedge clk); #1;
        end
    endtask

    task automatic poll_done(input string n);
        for (int k = 0; k < 16; k++) begin
            rd(A_STAT, n);
            if (!m_pend) return;
        end
    endtask

    always @(negedge clk) begin
        if (ack) begin
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 32'h1, 32'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.rd) check(e.name, dat_o, e.exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(A_CTRL, "rst_ctrl");
        rd(A_OPS,  "rst_ops");
        rd(A_STAT, "rst_stat");
        rd(A_RES,  "rst_res");

        // Unsigned 200*250
        wr(A_CTRL, 32'h0, 4'b0001, "u_ctrl");
        wr(A_OPS, 32'h0000_FAC8, 4'b0011, "u_ops");
        wr(A_CTRL, 32'h1, 4'b0001, "u_start");
        rd(A_CTRL, "u_ctrl_rd");
        poll_done("u_poll");
        rd(A_RES, "u_res");

        // Signed, START and SIGNED in the same write
        wr(A_STAT, 32'h2, 4'b0001, "s_clr");
        wr(A_OPS, 32'h0000_05FD, 4'b0011, "s_ops");
        wr(A_CTRL, 32'h3, 4'b0001, "s_start");
        poll_done("s_poll");
        rd(A_RES, "s_res");
        wr(A_OPS, 32'h0000_8080, 4'b0011, "s80_ops");
        wr(A_CTRL, 32'h3, 4'b0001, "s80_start");
        poll_done("s80_poll");
        rd(A_RES, "s80_res");

        // START during RUN, operand rewrite while busy, DONE W1C with irq enabled
        wr(A_STAT, 32'h2, 4'b0001, "b_clr");
        wr(A_OPS, 32'h0000_0D0B, 4'b0011, "b_ops");
        wr(A_CTRL, 32'h5, 4'b0001, "b_start");
        wr(A_OPS, 32'h0000_F3E7, 4'b0011, "b_ops_busy");
        wr(A_CTRL, 32'h7, 4'b0001, "b_restart");
        rd(A_STAT, "b_stat_err");
        poll_done("b_poll");
        rd(A_RES, "b_res");
        idle(3);
        wr(A_STAT, 32'h2, 4'b0001, "b_done_clr");
        rd(A_STAT, "b_stat_clr");
        idle(12);
        rd(A_STAT, "b_stat_once");
        wr(A_STAT, 32'h4, 4'b0001, "b_err_clr");
        rd(A_STAT, "b_stat_final");

        // DONE W1C landing in the FIN cycle
        wr(A_CTRL, 32'h5, 4'b0001, "c_start");
        idle(1);
        rd(A_STAT, "c_stat1");
        rd(A_STAT, "c_stat2");
        rd(A_STAT, "c_stat3");
        wr(A_STAT, 32'h2, 4'b0001, "c_clr_fin");
        rd(A_STAT, "c_stat_after");

        // Bus rules: unmapped decode and byte enables
        rd(A_UNMAP, "m_unmap_rd");
        wr(A_UNMAP, 32'hFFFF_FFFF, 4'hF, "m_unmap_wr");
        rd(A_CTRL, "m_ctrl_after");
        wr(A_OPS, 32'h0000_2233, 4'b0011, "m_ops_init");
        wr(A_OPS, 32'hFFFF_FF11, 4'b0001, "m_ops_sel");
        rd(A_OPS, "m_ops_rd");
        wr(A_RES, 32'hFFFF_FFFF, 4'hF, "m_res_wr");
        rd(A_RES, "m_res_ro");

        // Reset mid-RUN with DONE and IRQ_EN set
        wr(A_CTRL, 32'h5, 4'b0001, "r_start");
        @(posedge clk); #1;
        check("r_pre_irq", 32'(irq), 32'(m_done & m_irq_en));
        #1;
        rst_n = 1'b0;
        #1;
        check("r_mid_ack", 32'(ack), 32'h0);
        check("r_mid_dat", dat_o, 32'h0);
        check("r_mid_irq", 32'(irq), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(A_STAT, "r_stat");
        rd(A_RES,  "r_res");
        rd(A_OPS,  "r_ops");
        wr(A_OPS, 32'h0000_0709, 4'b0011, "r_ops_new");
        wr(A_CTRL, 32'h1, 4'b0001, "r_start_new");
        poll_done("r_poll");
        rd(A_RES, "r_res_new");

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            wr(A_STAT, 32'h6, 4'b0001, "x_clr");
            wr(A_OPS, {16'h0, 16'($urandom)}, 4'b0011, "x_ops");
            wr(A_CTRL, {29'h0, 1'($urandom), 1'($urandom), 1'b1}, 4'b0001, "x_start");
            idle($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                wr(A_CTRL, {29'h0, 1'($urandom), 1'($urandom), 1'b1}, 4'b0001, "x_restart");
            if ($urandom_range(0, 3) == 0)
                wr(A_OPS, $urandom, 4'($urandom), "x_ops_busy");
            poll_done("x_poll");
            rd(A_RES, "x_res");
            if ($urandom_range(0, 1) == 0) rd(A_CTRL, "x_ctrl");
            if ($urandom_range(0, 1) == 0) rd(A_OPS, "x_ops_rd");
            wr(A_STAT, {29'h0, 1'($urandom), 1'($urandom), 1'b0}, 4'b0001, "x_w1c");
            rd(A_STAT, "x_stat");
        end

        idle(2);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
